// File: rtl/saph_types_pkg.sv
// Shared pixel-pipeline types for the saph rasteriser back end: pixel, channel
// and format descriptors, framebuffer write record, and the standard formats.
package saph_types;

    typedef struct packed {
        logic [4:0] pos;
        logic [2:0] width;
    } chfmt;

    typedef struct packed {
        logic [4:0] size;
        chfmt       a;
        chfmt       r;
        chfmt       g;
        chfmt       b;
    } pixfmt;

    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic [15:0]        z;
        logic [15:0]        u;
        logic [15:0]        v;
        logic [31:0]        col;
    } pixel;

    // Address field is sized for the widest framebuffer the pipeline supports.
    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] data;
        logic [1:0]  nbytes;
    } fbwrite;

    // Alpha sits above bit 15 so the 16-bit mask removes it.
    localparam pixfmt SAPH_PIXFMT_RGB565 = '{
        size: 5'd15,
        a: '{pos: 5'd16, width: 3'd7},
        r: '{pos: 5'd11, width: 3'd4},
        g: '{pos: 5'd5,  width: 3'd5},
        b: '{pos: 5'd0,  width: 3'd4}
    };

    localparam pixfmt SAPH_PIXFMT_ARGB8888 = '{
        size: 5'd31,
        a: '{pos: 5'd24, width: 3'd7},
        r: '{pos: 5'd16, width: 3'd7},
        g: '{pos: 5'd8,  width: 3'd7},
        b: '{pos: 5'd0,  width: 3'd7}
    };

    function automatic logic [31:0] saph_size_mask(input logic [1:0] nbytes);
        case (nbytes)
            2'd0:    return 32'h0000_00FF;
            2'd1:    return 32'h0000_FFFF;
            2'd2:    return 32'h00FF_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/saph_pixel_pack_chan.sv
// Places one 8-bit colour channel into a 32-bit word: keeps the top width+1
// bits of the channel and shifts them to the channel's bit position.
module saph_chan_pack
    import saph_types::*;
(
    input  chfmt        cf,
    input  logic [7:0]  ch,
    output logic [31:0] field
);

    logic [7:0] val;

    assign val   = ch >> (3'd7 - cf.width);
    assign field = {24'd0, val} << cf.pos;

endmodule

// File: rtl/saph_pixel_pack.sv
// Two-stage pixel packer: format packing and row offset, then final address.
// Optional bounds clipping is enabled by defining SAPH_PIXPACK_CLIP_EN.
module saph_pixel_pack
    import saph_types::*;
#(
    parameter int ADDR_W    = 32,
    parameter int CLIPCNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  pixel                 in_pix,
    input  pixfmt                fmt,
    input  logic [ADDR_W-1:0]    fb_base,
    input  logic [15:0]          fb_stride,
    input  logic [15:0]          fb_w,
    input  logic [15:0]          fb_h,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ADDR_W-1:0]    out_addr,
    output logic [31:0]          out_data,
    output logic [1:0]           out_nbytes,
    output logic                 busy,
    output logic                 fmt_err,
    output logic [CLIPCNT_W-1:0] clip_count
);

    logic [31:0]       field_a, field_r, field_g, field_b;
    logic              fmt_ok, clip_in, accept, s1_adv;
    logic [1:0]        nbytes_in;
    logic [ADDR_W-1:0] x_ext, y_ext, stride_ext, bpp_p1;

    logic              vld_p1_d, vld_p1_q;
    logic [31:0]       data_p1_d, data_p1_q;
    logic [1:0]        nbytes_p1_d, nbytes_p1_q;
    logic [ADDR_W-1:0] yoff_p1_d, yoff_p1_q;
    logic [ADDR_W-1:0] x_p1_d, x_p1_q;
    logic [ADDR_W-1:0] base_p1_d, base_p1_q;

    logic              vld_p2_d, vld_p2_q;
    fbwrite            wr_p2_d, wr_p2_q;
    logic              fmt_err_d, fmt_err_q;
    logic              unused_pix;

    saph_chan_pack u_chan_a (.cf(fmt.a), .ch(in_pix.col[31:24]), .field(field_a));
    saph_chan_pack u_chan_r (.cf(fmt.r), .ch(in_pix.col[23:16]), .field(field_r));
    saph_chan_pack u_chan_g (.cf(fmt.g), .ch(in_pix.col[15:8]),  .field(field_g));
    saph_chan_pack u_chan_b (.cf(fmt.b), .ch(in_pix.col[7:0]),   .field(field_b));

    assign unused_pix = ^{in_pix.z, in_pix.u, in_pix.v};

    // Only whole-byte sizes (low three bits all ones) are packable.
    assign fmt_ok     = (fmt.size[2:0] == 3'b111);
    assign nbytes_in  = fmt.size[4:3];
    assign x_ext      = ADDR_W'(in_pix.x);
    assign y_ext      = ADDR_W'(in_pix.y);
    assign stride_ext = ADDR_W'(fb_stride);

    assign s1_adv   = !vld_p2_q || out_ready;
    assign in_ready = !rst && (!vld_p1_q || s1_adv);
    assign accept   = in_valid && in_ready;

`ifdef SAPH_PIXPACK_CLIP_EN
    logic [CLIPCNT_W-1:0] clip_count_d, clip_count_q;

    always_comb begin
        clip_in = in_pix.x[15] || in_pix.y[15] ||
                  ({1'b0, in_pix.x[14:0]} >= fb_w) ||
                  ({1'b0, in_pix.y[14:0]} >= fb_h);
        clip_count_d = clip_count_q;
        if (accept && clip_in && (clip_count_q != '1)) begin
            clip_count_d = clip_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clip_count_q <= '0;
        end else begin
            clip_count_q <= clip_count_d;
        end
    end

    assign clip_count = clip_count_q;
`else
    logic unused_fb_size;

    assign unused_fb_size = ^{fb_w, fb_h};
    assign clip_in        = 1'b0;
    assign clip_count     = '0;
`endif

    // Stage 1: packed colour word, row offset and latched configuration.
    always_comb begin
        vld_p1_d    = vld_p1_q;
        data_p1_d   = data_p1_q;
        nbytes_p1_d = nbytes_p1_q;
        yoff_p1_d   = yoff_p1_q;
        x_p1_d      = x_p1_q;
        base_p1_d   = base_p1_q;
        fmt_err_d   = fmt_err_q || (accept && !fmt_ok);
        if (s1_adv) begin
            vld_p1_d = 1'b0;
        end
        if (accept) begin
            vld_p1_d    = fmt_ok && !clip_in;
            data_p1_d   = (field_a | field_r | field_g | field_b) & saph_size_mask(nbytes_in);
            nbytes_p1_d = nbytes_in;
            yoff_p1_d   = y_ext * stride_ext;
            x_p1_d      = x_ext;
            base_p1_d   = fb_base;
        end
    end

    // Stage 2: final byte address and the write request held for the consumer.
    assign bpp_p1 = ADDR_W'(nbytes_p1_q) + ADDR_W'(1);

    always_comb begin
        vld_p2_d = vld_p2_q;
        wr_p2_d  = wr_p2_q;
        if (s1_adv) begin
            vld_p2_d = vld_p1_q;
            if (vld_p1_q) begin
                wr_p2_d.addr   = 64'(base_p1_q + yoff_p1_q + x_p1_q * bpp_p1);
                wr_p2_d.data   = data_p1_q;
                wr_p2_d.nbytes = nbytes_p1_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            wr_p2_q   <= '0;
            fmt_err_q <= 1'b0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            vld_p2_q  <= vld_p2_d;
            wr_p2_q   <= wr_p2_d;
            fmt_err_q <= fmt_err_d;
        end
    end

    always_ff @(posedge clk) begin
        data_p1_q   <= data_p1_d;
        nbytes_p1_q <= nbytes_p1_d;
        yoff_p1_q   <= yoff_p1_d;
        x_p1_q      <= x_p1_d;
        base_p1_q   <= base_p1_d;
    end

    assign out_valid  = vld_p2_q;
    assign out_addr   = ADDR_W'(wr_p2_q.addr);
    assign out_data   = wr_p2_q.data;
    assign out_nbytes = wr_p2_q.nbytes;
    assign busy       = vld_p1_q || vld_p2_q;
    assign fmt_err    = fmt_err_q;

endmodule

// File: tb/tb_saph_pixel_pack.sv
// Scoreboard bench for saph_pixel_pack; define SAPH_PIXPACK_CLIP_EN to also
// exercise bounds clipping.
module tb_saph_pixel_pack;
    import saph_types::*;

    localparam int ADDR_W    = 32;
    localparam int CLIPCNT_W = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    pixel                 in_pix;
    pixfmt                fmt;
    logic [ADDR_W-1:0]    fb_base;
    logic [15:0]          fb_stride;
    logic [15:0]          fb_w;
    logic [15:0]          fb_h;
    logic                 out_valid;
    logic                 out_ready;
    logic [ADDR_W-1:0]    out_addr;
    logic [31:0]          out_data;
    logic [1:0]           out_nbytes;
    logic                 busy;
    logic                 fmt_err;
    logic [CLIPCNT_W-1:0] clip_count;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  nb;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    saph_pixel_pack #(.ADDR_W(ADDR_W), .CLIPCNT_W(CLIPCNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pix(in_pix), .fmt(fmt), .fb_base(fb_base), .fb_stride(fb_stride),
        .fb_w(fb_w), .fb_h(fb_h), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .out_nbytes(out_nbytes),
        .busy(busy), .fmt_err(fmt_err), .clip_count(clip_count)
    );

    function automatic logic [31:0] m_addr(input logic [31:0] base, input int x, input int y,
                                           input int stride, input int bpp);
        longint a;
        a = longint'(base) + longint'(y) * longint'(stride) + longint'(x) * longint'(bpp);
        return a[31:0];
    endfunction

    function automatic logic [31:0] m_data(input logic is565, input logic [31:0] col);
        if (is565) return {16'h0, col[23:19], col[15:10], col[7:3]};
        return col;
    endfunction

    function automatic pixel mkpix(input int x, input int y, input logic [31:0] col);
        pixel p;
        p     = '0;
        p.x   = x[15:0];
        p.y   = y[15:0];
        p.col = col;
        return p;
    endfunction

    // Output monitor: pops the scoreboard on every completed write and
    // checks that a stalled request holds its values.
    logic        stall_prev = 1'b0;
    logic [31:0] st_addr, st_data;
    logic [1:0]  st_nb;
    exp_t        e;

    always @(negedge clk) begin
        if (rst !== 1'b0) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (out_valid !== 1'b1 || out_addr !== st_addr || out_data !== st_data ||
                    out_nbytes !== st_nb) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b addr=%h data=%h nb=%0d, need v=1 addr=%h data=%h nb=%0d",
                             out_valid, out_addr, out_data, out_nbytes, st_addr, st_data, st_nb);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got addr=%h data=%h, need no write", out_addr, out_data);
                end else begin
                    e = sbq.pop_front();
                    if (out_addr !== e.addr || out_data !== e.data || out_nbytes !== e.nb) begin
                        errors++;
                        $display("FAIL write: got addr=%h data=%h nb=%0d, need addr=%h data=%h nb=%0d",
                                 out_addr, out_data, out_nbytes, e.addr, e.data, e.nb);
                    end
                end
            end
            stall_prev = (out_valid === 1'b1) && (out_ready === 1'b0);
            st_addr    = out_addr;
            st_data    = out_data;
            st_nb      = out_nbytes;
        end
    end

    task automatic send(input pixel p, input pixfmt f, input logic [31:0] base,
                        input logic [15:0] stride, input logic push,
                        input logic [31:0] ea, input logic [31:0] ed, input logic [1:0] en);
        bit   done;
        exp_t x;
        in_pix    = p;
        fmt       = f;
        fb_base   = base;
        fb_stride = stride;
        in_valid  = 1'b1;
        done      = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                if (push) begin
                    x.addr = ea;
                    x.data = ed;
                    x.nb   = en;
                    sbq.push_back(x);
                end
                @(posedge clk);
                #1;
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 for 200 cycles, need 1");
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input int maxc);
        bit done = 1'b0;
        for (int k = 0; k < maxc; k++) begin
            @(negedge clk);
            if (sbq.size() == 0 && busy === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain: got %0d pending busy=%b, need 0 pending busy=0", sbq.size(), busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_pix    = '0;
        fmt       = SAPH_PIXFMT_ARGB8888;
        fb_base   = '0;
        fb_stride = '0;
        fb_w      = 16'd100;
        fb_h      = 16'd100;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, need 0", in_ready);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || fmt_err !== 1'b0 ||
            clip_count !== '0 || out_addr !== '0 || out_data !== '0 || out_nbytes !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b v=%b busy=%b ferr=%b clip=%0d addr=%h data=%h nb=%0d, need 1 0 0 0 0 0 0 0",
                     in_ready, out_valid, busy, fmt_err, clip_count, out_addr, out_data, out_nbytes);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_rgb565();
        send(mkpix(3, 2, 32'hFFFF8000), SAPH_PIXFMT_RGB565, 32'h1000, 16'd640,
             1'b1, 32'h0000_1506, 32'h0000_FC00, 2'd1);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: got out_valid=%b one cycle after accept, need 0", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency: got out_valid=%b two cycles after accept, need 1", out_valid);
        end
        wait_drain(20);
    endtask

    task automatic test_back_to_back();
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    logic [31:0] col, base;
                    col  = $urandom;
                    base = 32'h2000 + 32'(i) * 32'h40;
                    send(mkpix(i * 3, i, col), SAPH_PIXFMT_ARGB8888, base, 16'd256, 1'b1,
                         m_addr(base, i * 3, i, 256, 4), m_data(1'b0, col), 2'd3);
                end
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                checks++;
                if (in_ready !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL full_backpressure: got in_ready=%b busy=%b, need 0 1", in_ready, busy);
                end
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain(50);
    endtask

    task automatic test_config_change();
        send(mkpix(5, 1, 32'h12345678), SAPH_PIXFMT_RGB565, 32'h1000, 16'd640, 1'b1,
             m_addr(32'h1000, 5, 1, 640, 2), m_data(1'b1, 32'h12345678), 2'd1);
        send(mkpix(7, 3, 32'h89ABCDEF), SAPH_PIXFMT_ARGB8888, 32'h8000, 16'd100, 1'b1,
             m_addr(32'h8000, 7, 3, 100, 4), 32'h89ABCDEF, 2'd3);
        in_valid  = 1'b0;
        fmt       = SAPH_PIXFMT_RGB565;
        fb_base   = 32'hDEAD0000;
        fb_stride = 16'd3;
        wait_drain(20);
    endtask

    task automatic test_fmt_err();
        pixfmt bad;
        bad      = SAPH_PIXFMT_RGB565;
        bad.size = 5'd11;
        send(mkpix(1, 1, 32'hFFFFFFFF), bad, 32'h1000, 16'd64, 1'b0, '0, '0, '0);
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (fmt_err !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL fmt_err_drop: got fmt_err=%b out_valid=%b, need 1 0", fmt_err, out_valid);
            end
        end
        @(posedge clk);
        #1;
        send(mkpix(2, 0, 32'h00A0B0C0), SAPH_PIXFMT_ARGB8888, 32'h400, 16'd64, 1'b1,
             m_addr(32'h400, 2, 0, 64, 4), 32'h00A0B0C0, 2'd3);
        in_valid = 1'b0;
        wait_drain(20);
        checks++;
        if (fmt_err !== 1'b1) begin
            errors++;
            $display("FAIL fmt_err_sticky: got %b, need 1", fmt_err);
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (fmt_err !== 1'b0) begin
            errors++;
            $display("FAIL fmt_err_clear: got %b, need 0", fmt_err);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_midstream_reset();
        out_ready = 1'b0;
        send(mkpix(1, 1, 32'h11111111), SAPH_PIXFMT_ARGB8888, 32'h100, 16'd16, 1'b0, '0, '0, '0);
        send(mkpix(2, 1, 32'h22222222), SAPH_PIXFMT_ARGB8888, 32'h100, 16'd16, 1'b0, '0, '0, '0);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL both_full: got out_valid=%b in_ready=%b, need 1 0", out_valid, in_ready);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_addr !== '0 || out_data !== '0) begin
            errors++;
            $display("FAIL midstream_reset: got v=%b busy=%b addr=%h data=%h, need 0 0 0 0",
                     out_valid, busy, out_addr, out_data);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_write: got out_valid=%b, need 0", out_valid);
            end
        end
        @(posedge clk);
        #1;
    endtask

`ifdef SAPH_PIXPACK_CLIP_EN
    task automatic test_clip();
        send(mkpix(-1, 0, 32'h01010101), SAPH_PIXFMT_ARGB8888, 32'h0, 16'd400, 1'b0, '0, '0, '0);
        send(mkpix(100, 5, 32'h02020202), SAPH_PIXFMT_ARGB8888, 32'h0, 16'd400, 1'b0, '0, '0, '0);
        send(mkpix(99, 99, 32'h03030303), SAPH_PIXFMT_ARGB8888, 32'h0, 16'd400, 1'b1,
             m_addr(32'h0, 99, 99, 400, 4), 32'h03030303, 2'd3);
        in_valid = 1'b0;
        wait_drain(20);
        checks++;
        if (clip_count !== 16'd2) begin
            errors++;
            $display("FAIL clip_count: got %0d, need 2", clip_count);
        end
    endtask
`else
    task automatic test_wrap();
        send(mkpix(-1, 0, 32'hCAFEF00D), SAPH_PIXFMT_ARGB8888, 32'h100, 16'd64, 1'b1,
             32'h0000_00FC, 32'hCAFEF00D, 2'd3);
        send(mkpix(0, -1, 32'h0000BEEF), SAPH_PIXFMT_RGB565, 32'h1000, 16'h100, 1'b1,
             32'h0000_0F00, m_data(1'b1, 32'h0000BEEF), 2'd1);
        send(mkpix(-2, -1, 32'h55555555), SAPH_PIXFMT_ARGB8888, 32'h0, 16'd8, 1'b1,
             32'hFFFF_FFF0, 32'h55555555, 2'd3);
        in_valid = 1'b0;
        wait_drain(20);
        checks++;
        if (clip_count !== '0) begin
            errors++;
            $display("FAIL clip_count_tied: got %0d, need 0", clip_count);
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, need completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rgb565();
        test_back_to_back();
        test_config_change();
        test_fmt_err();
        test_midstream_reset();
`ifdef SAPH_PIXPACK_CLIP_EN
        test_clip();
`else
        test_wrap();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
